// File: rtl/vga_timing_decoder.sv
// Receive-side VGA timing recovery: rebuilds pixel position from active-low syncs,
// measures line/frame periods and locks when they match the configured mode.
module vga_timing_decoder #(
  parameter int unsigned H_DISPLAY   = 640,
  parameter int unsigned H_FRONT     = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BACK      = 48,
  parameter int unsigned V_DISPLAY   = 480,
  parameter int unsigned V_FRONT     = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BACK      = 33,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        h_sync_in,
  input  logic        v_sync_in,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        display_en,
  output logic        locked,
  output logic [10:0] line_len,
  output logic [9:0]  frame_lines,
  output logic        h_err,
  output logic        v_err
);

  localparam int unsigned H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int unsigned HS_START = H_DISPLAY + H_FRONT;
  localparam int unsigned VS_START = V_DISPLAY + V_FRONT;

  localparam logic [9:0]  HC_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0]  VC_LAST      = 10'(V_TOTAL - 1);
  localparam logic [9:0]  HC_AT_SYNC   = 10'(HS_START + 1);
  localparam logic [9:0]  VC_AT_SYNC   = 10'(VS_START);
  localparam logic [9:0]  HC_DISP      = 10'(H_DISPLAY);
  localparam logic [9:0]  VC_DISP      = 10'(V_DISPLAY);
  localparam logic [10:0] LINE_OK      = 11'(H_TOTAL);
  localparam logic [10:0] LINE_TIMEOUT = 11'(2 * H_TOTAL);
  localparam logic [9:0]  FRAME_OK     = 10'(V_TOTAL);
  localparam logic [2:0]  MC_LOCK      = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, H_SEEN, MEASURE, LOCKED} state_t;

  state_t      state, state_next;
  logic        h_prev, v_prev;
  logic        hfall, vfall, h_wrap;
  logic [9:0]  hc, vc;
  logic [10:0] lc;
  logic [9:0]  fc, fc_inc;
  logic [2:0]  mc, mc_next, mc_plus;
  logic        first_h, first_h_next;
  logic        h_err_next, v_err_next;
  logic        h_bad, timeout, frame_good;

  assign hfall   = h_prev & ~h_sync_in;
  assign vfall   = v_prev & ~v_sync_in;
  assign h_wrap  = (hc == HC_LAST);
  // A line wrap on the vfall cycle still belongs to the frame being closed.
  assign fc_inc  = (h_wrap && fc != '1) ? fc + 10'd1 : fc;
  assign mc_plus = mc + 3'd1;

  assign x          = hc;
  assign y          = vc;
  assign display_en = locked && (hc < HC_DISP) && (vc < VC_DISP);

  always_ff @(posedge clk) begin
    if (reset) begin
      h_prev      <= 1'b1;
      v_prev      <= 1'b1;
      hc          <= '0;
      vc          <= '0;
      lc          <= '0;
      fc          <= '0;
      line_len    <= '0;
      frame_lines <= '0;
    end else begin
      h_prev <= h_sync_in;
      v_prev <= v_sync_in;

      if (hfall)       hc <= HC_AT_SYNC;
      else if (h_wrap) hc <= '0;
      else             hc <= hc + 10'd1;

      if (vfall)       vc <= VC_AT_SYNC + 10'(h_wrap);
      else if (h_wrap) vc <= (vc == VC_LAST) ? '0 : vc + 10'd1;

      if (hfall) begin
        line_len <= lc;
        lc       <= 11'd1;
      end else if (lc != '1) begin
        lc <= lc + 11'd1;
      end

      if (vfall) begin
        frame_lines <= fc_inc;
        fc          <= '0;
      end else begin
        fc <= fc_inc;
      end
    end
  end

  always_comb begin
    state_next   = state;
    mc_next      = mc;
    first_h_next = first_h;
    h_err_next   = 1'b0;
    v_err_next   = 1'b0;
    h_bad        = hfall && (lc != LINE_OK);
    timeout      = !hfall && (lc == LINE_TIMEOUT);
    frame_good   = (fc_inc == FRAME_OK) &&
                   (hfall ? (lc == LINE_OK) : (line_len == LINE_OK));

    unique case (state)
      SEARCH: begin
        if (hfall) state_next = H_SEEN;
      end
      H_SEEN: begin
        if (timeout) begin
          state_next = SEARCH;
        end else if (vfall) begin
          state_next   = MEASURE;
          mc_next      = '0;
          first_h_next = 1'b1;
        end
      end
      MEASURE: begin
        if (timeout) begin
          state_next = SEARCH;
        end else begin
          if (hfall) first_h_next = 1'b0;
          // The first hfall after entering MEASURE closes a line that began before measurement.
          if (h_bad && !first_h) begin
            mc_next = '0;
          end else if (vfall) begin
            if (frame_good) begin
              mc_next = mc_plus;
              if (mc_plus == MC_LOCK) state_next = LOCKED;
            end else begin
              mc_next = '0;
            end
          end
        end
      end
      LOCKED: begin
        if (timeout || h_bad) begin
          h_err_next = 1'b1;
          state_next = SEARCH;
        end else if (vfall && fc_inc != FRAME_OK) begin
          v_err_next = 1'b1;
          state_next = SEARCH;
        end
      end
      default: state_next = SEARCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SEARCH;
      mc      <= '0;
      first_h <= 1'b0;
      locked  <= 1'b0;
      h_err   <= 1'b0;
      v_err   <= 1'b0;
    end else begin
      state   <= state_next;
      mc      <= mc_next;
      first_h <= first_h_next;
      locked  <= (state_next == LOCKED);
      h_err   <= h_err_next;
      v_err   <= v_err_next;
    end
  end

endmodule

// File: tb/tb_vga_timing_decoder.sv
// Directed bench for vga_timing_decoder on a reduced 32x19 timing mode driven by
// a small sync generator with injectable short line, short frame and h_sync dropout.
module tb_vga_timing_decoder;

  localparam int HD = 20, HF = 4, HS = 6, HB = 2;
  localparam int VD = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT  = HD + HF + HS + HB;   // 32
  localparam int VT  = VD + VF + VS + VB;   // 19
  localparam int HSS = HD + HF;             // 24
  localparam int VSS = VD + VF;             // 14

  logic        clk = 1'b0;
  logic        reset;
  logic        h_sync_in, v_sync_in;
  logic [9:0]  x, y;
  logic        display_en, locked;
  logic [10:0] line_len;
  logic [9:0]  frame_lines;
  logic        h_err, v_err;

  vga_timing_decoder #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .x(x), .y(y), .display_en(display_en), .locked(locked),
    .line_len(line_len), .frame_lines(frame_lines), .h_err(h_err), .v_err(v_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ghc = 0, gvc = 0, cyc = 0, last_hfall = 0, mask = 0;
  bit short_line = 0, short_frame = 0;
  bit g_hfall = 0, g_vfall = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive();
    logic h_new, v_new;
    h_new = !(ghc >= HSS && ghc < HSS + HS) || (mask > 0);
    v_new = !(gvc >= VSS && gvc < VSS + VS);
    g_hfall = h_sync_in && !h_new;
    g_vfall = v_sync_in && !v_new;
    if (g_hfall) last_hfall = cyc;
    h_sync_in = h_new;
    v_sync_in = v_new;
  endtask

  // Advance one pixel clock; generator state afterwards describes the current cycle.
  task automatic tick();
    int hend, vend;
    @(posedge clk);
    #1;
    cyc++;
    if (mask > 0) mask--;
    hend = short_line  ? HT - 2 : HT - 1;
    vend = short_frame ? VT - 2 : VT - 1;
    if (ghc >= hend) begin
      ghc = 0;
      short_line = 0;
      if (gvc >= vend) begin
        gvc = 0;
        short_frame = 0;
      end else begin
        gvc++;
      end
    end else begin
      ghc++;
    end
    drive();
  endtask

  task automatic wait_vfalls(input int n, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < (n + 2) * HT * VT && seen < n; i++) begin
      tick();
      if (g_vfall) seen++;
    end
    check(tag, 32'(seen), 32'(n));
  endtask

  task automatic wait_hfalls(input int n, input string tag);
    int seen;
    seen = 0;
    for (int i = 0; i < (n + 2) * HT && seen < n; i++) begin
      tick();
      if (g_hfall) seen++;
    end
    check(tag, 32'(seen), 32'(n));
  endtask

  task automatic wait_locked(input string tag);
    for (int i = 0; i < 10 * HT * VT && !locked; i++) tick();
    check(tag, 32'(locked), 32'd1);
  endtask

  initial begin
    int den_cnt;
    logic exp_den;

    reset = 1'b1;
    h_sync_in = 1'b1;
    v_sync_in = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_x", 32'(x), 32'd0);
    check("rst_y", 32'(y), 32'd0);
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_line_len", 32'(line_len), 32'd0);
    check("rst_frame_lines", 32'(frame_lines), 32'd0);
    check("rst_errs", 32'({h_err, v_err}), 32'd0);
    check("rst_display_en", 32'(display_en), 32'd0);
    reset = 1'b0;

    // Lock from reset: one cycle after the third v_sync fall.
    wait_vfalls(3, "lock_wait");
    check("lock_pre", 32'(locked), 32'd0);
    tick();
    check("lock", 32'(locked), 32'd1);
    check("lock_line_len", 32'(line_len), 32'(HT));
    check("lock_frame_lines", 32'(frame_lines), 32'(VT));

    // Two frames of position tracking while locked.
    for (int f = 0; f < 2; f++) begin
      den_cnt = 0;
      for (int i = 0; i < HT * VT; i++) begin
        tick();
        exp_den = (ghc < HD) && (gvc < VD);
        check("xy", 32'({y, x}), 32'({10'(gvc), 10'(ghc)}));
        check("display_en", 32'(display_en), 32'(exp_den));
        if (display_en) den_cnt++;
      end
      check("display_count", 32'(den_cnt), 32'(HD * VD));
    end

    // One 31-cycle line while locked.
    wait_vfalls(1, "short_line_align");
    short_line = 1;
    wait_hfalls(2, "short_line_wait");
    check("short_line_pre", 32'({locked, h_err}), 32'b10);
    tick();
    check("short_line_h_err", 32'(h_err), 32'd1);
    check("short_line_unlock", 32'(locked), 32'd0);
    check("short_line_len", 32'(line_len), 32'(HT - 1));
    tick();
    check("short_line_pulse", 32'(h_err), 32'd0);
    wait_vfalls(3, "relock_wait");
    check("relock_pre", 32'(locked), 32'd0);
    tick();
    check("relock", 32'(locked), 32'd1);

    // h_sync dropout for three lines while locked: timeout at lc == 2*HT.
    for (int i = 0; i < HT && ghc != HSS + HS; i++) tick();
    mask = 3 * HT;
    for (int i = 0; i < 3 * HT && cyc < last_hfall + 2 * HT; i++) tick();
    check("timeout_wait", 32'(cyc), 32'(last_hfall + 2 * HT));
    check("timeout_pre", 32'({locked, h_err}), 32'b10);
    tick();
    check("timeout_h_err", 32'(h_err), 32'd1);
    check("timeout_unlock", 32'(locked), 32'd0);
    tick();
    check("timeout_pulse", 32'(h_err), 32'd0);
    check("timeout_search", 32'(locked), 32'd0);

    // One 18-line frame while locked.
    wait_locked("relock_after_timeout");
    wait_vfalls(1, "short_frame_align");
    short_frame = 1;
    wait_vfalls(1, "short_frame_wait");
    check("short_frame_pre", 32'({locked, v_err}), 32'b10);
    tick();
    check("short_frame_v_err", 32'(v_err), 32'd1);
    check("short_frame_unlock", 32'(locked), 32'd0);
    check("short_frame_lines", 32'(frame_lines), 32'(VT - 1));
    check("short_frame_h_err", 32'(h_err), 32'd0);
    tick();
    check("short_frame_pulse", 32'(v_err), 32'd0);

    // Single-cycle reset mid-frame while locked.
    wait_locked("relock_after_short_frame");
    repeat (100) tick();
    check("reset_pre_locked", 32'(locked), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset_x", 32'(x), 32'd0);
    check("reset_y", 32'(y), 32'd0);
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_line_len", 32'(line_len), 32'd0);
    check("reset_frame_lines", 32'(frame_lines), 32'd0);
    check("reset_display_en", 32'(display_en), 32'd0);
    repeat (HT * VT) tick();
    check("reset_no_early_lock", 32'(locked), 32'd0);
    wait_locked("relock_after_reset");
    for (int i = 0; i < HT; i++) begin
      tick();
      check("xy_after_reset", 32'({y, x}), 32'({10'(gvc), 10'(ghc)}));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_timing_decoder.md
# vga_timing_decoder

Receive-side counterpart of the VGA sync generator: it samples active-low h_sync/v_sync in the pixel-clock domain, recovers the pixel position, measures line and frame periods, and asserts `locked` once the incoming timing matches the configured 640x480@60 mode. It sits on capture/loopback paths and in the self-check bench, where it checks generator output and regenerates x/y/display_en for downstream pixel logic.

## Interface
- H_DISPLAY, 640, active pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BACK, 48, horizontal back porch; H_TOTAL = sum = 800
- V_DISPLAY, 480, active lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BACK, 33, vertical back porch; V_TOTAL = sum = 525
- LOCK_FRAMES, 2, consecutive matching frames required for lock
- clk  in  1  pixel clock
- reset  in  1  synchronous, active-high
- h_sync_in  in  1  active-low horizontal sync, synchronous to clk
- v_sync_in  in  1  active-low vertical sync, synchronous to clk
- x  out  10  recovered horizontal position (hc)
- y  out  10  recovered vertical position (vc)
- display_en  out  1  locked && hc < H_DISPLAY && vc < V_DISPLAY
- locked  out  1  timing matches parameters
- line_len  out  11  last measured cycles between h_sync falls
- frame_lines  out  10  last measured lines between v_sync falls
- h_err  out  1  one-cycle pulse: bad line period or h timeout while locked
- v_err  out  1  one-cycle pulse: bad frame length while locked

## Operation
- Edge detect: h_prev/v_prev registers (reset 1); hfall = h_prev & ~h_sync_in, vfall likewise; no synchronizer (same clock).
- Constants: HS_START = H_DISPLAY+H_FRONT (656), VS_START = V_DISPLAY+V_FRONT (490).
- hc: if hfall, hc <= HS_START+1; else if hc == H_TOTAL-1, hc <= 0; else hc+1.
- vc: if vfall, vc <= VS_START + (hc == H_TOTAL-1 ? 1 : 0); else if hc == H_TOTAL-1, vc <= (vc == V_TOTAL-1 ? 0 : vc+1).
- Line counter lc (11 b, saturates 2047): on hfall, line_len <= lc, lc <= 1; else lc+1.
- Frame counter fc (10 b, saturates 1023): +1 each hc wrap; on vfall, frame_lines <= fc, fc <= 0 (same-cycle wrap counts into old frame).
- FSM states SEARCH, H_SEEN, MEASURE, LOCKED; match counter mc (3 b).
  - SEARCH: first hfall -> H_SEEN.
  - H_SEEN: first vfall -> MEASURE, mc <= 0.
  - MEASURE: each vfall, if frame_lines-to-be == V_TOTAL and line_len == H_TOTAL then mc+1 else mc <= 0; when mc would reach LOCK_FRAMES -> LOCKED. Any hfall with lc != H_TOTAL (except first in MEASURE) clears mc.
  - LOCKED: hfall with lc != H_TOTAL -> h_err, SEARCH. vfall with fc != V_TOTAL -> v_err, SEARCH.
  - Any state except SEARCH: lc reaching 2*H_TOTAL without hfall -> SEARCH (h_err only if LOCKED).
- locked = (state == LOCKED), registered with state. hc/vc free-run in all states.
- Simultaneous hfall and vfall: both processed same cycle; h check evaluated first, failure wins.

## Timing
- Reset values: hc=0, vc=0, lc=0, fc=0, line_len=0, frame_lines=0, locked=0, h_err=0, v_err=0, display_en=0, state SEARCH.
- x/y: zero latency once aligned; in the cycle after an hfall, x == generator count (HS_START+1).
- locked rises the cycle after the vfall completing LOCK_FRAMES matching frames; falls the cycle after the failing edge, with the err pulse in that same cycle.
- display_en combinational from registered hc, vc, locked.
- Reset mid-lock: all outputs return to reset values next cycle; relock requires full sequence.

## Test plan
- Ideal 800x525 generator stimulus from reset -> locked=1 one cycle after third v_sync fall; line_len=800, frame_lines=525.
- After lock, compare x/y/display_en to generator counts every cycle for 2 frames -> exact match, display_en high 640x480 = 307200 cycles per frame.
- One line shortened to 799 cycles while locked -> h_err one-cycle pulse, locked=0 next cycle, relock after 3 clean v falls.
- h_sync held high 1600 cycles while locked -> h_err pulse, state SEARCH, locked=0.
- Frame of 524 lines while locked -> v_err pulse, frame_lines=524, locked=0.
- reset asserted one cycle mid-frame while locked -> next cycle x=0, y=0, locked=0, line_len=0.
